// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_burst shared types and control-word layout.
// States, bit positions and small width helpers.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  localparam int SEND_BIT  = 0;
  localparam int CLEAR_BIT = 1;
  localparam int NTX_LSB   = 2;

  // cs_sel sits directly above the n_tx field
  function automatic int cs_lsb(input int cnt_w);
    return NTX_LSB + cnt_w;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_ctrl_burst_edge_pend.sv
// Rising-edge detector feeding a set/consume pending latch.
// A new rise wins over a same-cycle consume.
module edge_pend (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  input  logic i_consume,
  output logic o_pend
);

  logic r_q;
  logic r_pend;
  logic w_rise;

  assign w_rise = i_lvl & ~r_q;
  assign o_pend = r_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_q    <= i_lvl;
      r_pend <= (r_pend & ~i_consume) | w_rise;
    end
  end

endmodule

// File: rtl/spi_ctrl_burst.sv
// Burst SPI transaction controller: decodes the control word,
// sequences N transfers and strobes data/control write-backs.
module spi_ctrl_burst
  import spi_ctrl_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int CNT_W   = 8,
  parameter  int N_CS    = 4,
  parameter  int TIMEOUT = 1024,
  localparam int CS_W    = clog2_min1(N_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data_control,
  input  logic              i_spi_done,
  output logic              o_send,
  output logic              o_clear,
  output logic              eneable_SPI,
  output logic [CS_W-1:0]   o_cs,
  output logic [CNT_W-1:0]  transac,
  output logic              WR2D,
  output logic              WR2C,
  output logic [DATA_W-1:0] o_ctrl_wb,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_ovf
);

  localparam int CSL  = cs_lsb(CNT_W);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t r_state;
  state_t w_nxt;

  logic              w_send_pend;
  logic              w_clr_pend;
  logic              w_send_take;
  logic              w_clr_take;
  logic [CNT_W-1:0]  w_ntx;
  logic [CS_W-1:0]   w_cs_sel;
  logic              w_cs_bad;
  logic              w_tmo_hit;
  logic [CNT_W-1:0]  r_rem;
  logic [TW-1:0]     r_tmo;
  logic [CS_W-1:0]   r_cs;
  logic [CNT_W-1:0]  r_transac;
  logic              r_err;
  logic              r_ovf;

  assign w_ntx     = i_data_control[NTX_LSB +: CNT_W];
  assign w_cs_sel  = i_data_control[CSL +: CS_W];
  assign w_cs_bad  = {1'b0, w_cs_sel} >= (CS_W + 1)'(N_CS);
  assign w_tmo_hit = r_tmo == TMO_LAST;

  edge_pend u_send (
    .clk       (clk),
    .rst       (rst),
    .i_lvl     (i_data_control[SEND_BIT]),
    .i_consume (w_send_take),
    .o_pend    (w_send_pend)
  );

  edge_pend u_clr (
    .clk       (clk),
    .rst       (rst),
    .i_lvl     (i_data_control[CLEAR_BIT]),
    .i_consume (w_clr_take),
    .o_pend    (w_clr_pend)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_send_take = 1'b0;
    w_clr_take  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_clr_pend) begin
          w_clr_take = 1'b1;
          w_nxt      = S_CLEAR;
        end else if (w_send_pend) begin
          w_send_take = 1'b1;
          w_nxt       = w_cs_bad ? S_DONE : S_START;
        end
      end
      S_CLEAR: w_nxt = S_IDLE;
      S_START: w_nxt = S_WAIT;
      S_WAIT: begin
        if (i_spi_done)     w_nxt = S_STORE;
        else if (w_tmo_hit) w_nxt = S_DONE;
      end
      S_STORE: w_nxt = (r_rem == CNT_W'(1)) ? S_DONE : S_START;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem     <= '0;
      r_tmo     <= '0;
      r_cs      <= '0;
      r_transac <= '0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_send_take) begin
            r_rem <= (w_ntx == '0) ? CNT_W'(1) : w_ntx;
            r_cs  <= w_cs_sel;
            if (w_cs_bad) r_err <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_transac <= '0;
          r_err     <= 1'b0;
          r_ovf     <= 1'b0;
        end
        S_START: r_tmo <= '0;
        S_WAIT: begin
          if (!i_spi_done) begin
            if (w_tmo_hit) r_err <= 1'b1;
            else           r_tmo <= r_tmo + 1'b1;
          end
        end
        S_STORE: begin
          r_transac <= r_transac + 1'b1;
          if (&r_transac) r_ovf <= 1'b1;
          r_rem <= r_rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_send      = r_state == S_START;
  assign o_clear     = r_state == S_CLEAR;
  assign WR2D        = r_state == S_STORE;
  assign WR2C        = r_state == S_DONE;
  assign eneable_SPI = o_send | WR2D | (r_state == S_WAIT);
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_CLEAR);
  assign o_cs        = r_cs;
  assign transac     = r_transac;
  assign o_err       = r_err;
  assign o_ovf       = r_ovf;
  assign o_ctrl_wb   = WR2C ?
    {i_data_control[DATA_W-1:1], 1'b0} : '0;

endmodule

// File: tb/tb_spi_ctrl_burst.sv
// Scoreboard bench for spi_ctrl_burst: random bursts vs a
// transfer-level reference model of addresses and flags.
module tb_spi_ctrl_burst;

  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct {
    logic [DW-1:0] wb;
    logic [1:0]    cs;
    logic          err;
    logic          ovf;
  } wc_t;

  logic          clk = 0;
  logic          rst = 0;
  logic [DW-1:0] ctrl = '0;
  logic          done = 0;
  logic          o_send, o_clear, en, wr2d, wr2c;
  logic          o_busy, o_err, o_ovf;
  logic [1:0]    o_cs;
  logic [CW-1:0] transac;
  logic [DW-1:0] o_wb;

  int n_chk  = 0;
  int n_fail = 0;
  int send_cnt = 0;
  int clr_cnt  = 0;
  int xfers    = 0;

  logic [CW-1:0] addr_q[$];
  wc_t           wc_q[$];

  int  m_addr = 0;
  bit  m_ovf  = 0;
  bit  m_err  = 0;

  spi_ctrl_burst #(
    .DATA_W(DW), .CNT_W(CW), .N_CS(4), .TIMEOUT(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_data_control (ctrl),
    .i_spi_done     (done),
    .o_send         (o_send),
    .o_clear        (o_clear),
    .eneable_SPI    (en),
    .o_cs           (o_cs),
    .transac        (transac),
    .WR2D           (wr2d),
    .WR2C           (wr2c),
    .o_ctrl_wb      (o_wb),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_ovf          (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops expected strobes as the DUT presents them
  always @(negedge clk) begin
    if (rst) begin
      if (o_send)  send_cnt++;
      if (o_clear) clr_cnt++;
      if (wr2d) begin
        if (addr_q.size() == 0) chk("wr2d_unexpected", 1, 0);
        else chk("wr2d_addr", transac, addr_q.pop_front());
        chk("wr2d_enable", en, 1);
      end
      if (wr2c) begin
        if (wc_q.size() == 0) chk("wr2c_unexpected", 1, 0);
        else begin
          wc_t e;
          e = wc_q.pop_front();
          chk("wr2c_wb", o_wb, e.wb);
          chk("wr2c_cs", o_cs, e.cs);
          chk("wr2c_err", o_err, e.err);
          chk("wr2c_ovf", o_ovf, e.ovf);
        end
      end
    end
  end

  task automatic wait_send(output bit ok);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_send) begin
        ok = 1;
        return;
      end
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!o_busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  // dly<0: random done latency; respond=0: never answer
  task automatic run_burst(input int ntx, input int cs,
                           input int dly, input bit respond,
                           input bit with_clr);
    logic [DW-1:0] w;
    int n;
    bit ok;
    wc_t e;
    w = $urandom;
    w[1:0] = 2'b00;
    w[9:2] = ntx[7:0];
    w[11:10] = cs[1:0];
    ctrl = w;
    @(negedge clk);
    n = (ntx == 0) ? 1 : ntx;
    if (with_clr) begin
      m_addr = 0;
      m_ovf  = 0;
      m_err  = 0;
    end
    if (respond) begin
      for (int i = 0; i < n; i++) begin
        addr_q.push_back(m_addr[CW-1:0]);
        if (m_addr == 255) m_ovf = 1;
        m_addr = (m_addr + 1) % 256;
      end
    end else m_err = 1;
    w[1] = with_clr;
    e.wb  = w;
    e.cs  = cs[1:0];
    e.err = m_err;
    e.ovf = m_ovf;
    wc_q.push_back(e);
    w[0] = 1'b1;
    ctrl = w;
    for (int i = 0; i < n; i++) begin
      wait_send(ok);
      if (!ok || !respond) break;
      @(negedge clk);
      repeat (dly < 0 ? $urandom_range(0, 3) : dly) @(negedge clk);
      done = 1;
      @(negedge clk);
      done = 0;
      xfers++;
    end
    wait_idle();
  endtask

  task automatic do_clear();
    int c0;
    c0 = clr_cnt;
    ctrl[1] = 0;
    @(negedge clk);
    ctrl[1] = 1;
    repeat (4) @(negedge clk);
    chk("clear_pulse", clr_cnt - c0, 1);
    chk("clear_err", o_err, 0);
    chk("clear_transac", transac, 0);
    chk("clear_ovf", o_ovf, 0);
    m_addr = 0;
    m_ovf  = 0;
    m_err  = 0;
    ctrl[1] = 0;
  endtask

  initial begin
    int s0, c0;
    bit ok;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_send", o_send, 0);
    chk("rst_clear", o_clear, 0);
    chk("rst_en", en, 0);
    chk("rst_cs", o_cs, 0);
    chk("rst_transac", transac, 0);
    chk("rst_wr2d", wr2d, 0);
    chk("rst_wr2c", wr2c, 0);
    chk("rst_wb", o_wb, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ovf", o_ovf, 0);

    run_burst(1, 2, 1, 1, 0);
    chk("b1_transac", transac, 1);

    s0 = send_cnt;
    repeat (20) @(negedge clk);
    chk("held_no_retrigger", send_cnt - s0, 0);
    run_burst(1, 1, -1, 1, 0);
    chk("b2_transac", transac, 2);

    s0 = send_cnt;
    run_burst(3, 0, 0, 1, 0);
    chk("b3_sends", send_cnt - s0, 3);
    chk("b3_transac", transac, 5);

    run_burst(2, 3, 0, 0, 0);
    chk("tmo_err", o_err, 1);
    chk("tmo_idle", o_busy, 0);
    do_clear();

    while (xfers < 320)
      run_burst($urandom_range(0, 8), $urandom_range(0, 3),
                -1, 1, 0);
    chk("wrap_ovf", o_ovf, 1);
    chk("wrap_transac", transac, m_addr);

    c0 = clr_cnt;
    run_burst(2, 1, -1, 1, 1);
    chk("sim_clear_pulse", clr_cnt - c0, 1);
    chk("sim_transac", transac, 2);
    chk("sim_ovf", o_ovf, 0);

    ctrl = '0;
    ctrl[9:2] = 8'd2;
    @(negedge clk);
    ctrl[0] = 1;
    wait_send(ok);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_en", en, 0);
    chk("arst_transac", transac, 0);
    chk("arst_wr2c", wr2c, 0);
    chk("arst_err", o_err, 0);
    ctrl = '0;
    m_addr = 0;
    m_ovf = 0;
    m_err = 0;
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", o_busy, 0);

    chk("addr_q_empty", addr_q.size(), 0);
    chk("wc_q_empty", wc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
